i2cs_pin_conditioner: RTL and testbench
=======================================

# i2cs_pin_conditioner

Input-conditioning stage for the I2C peripheral (slave). It sits between the raw `i2c_scl_i`/`i2c_sda_i` pins and the I2C peripheral protocol engine. It synchronises both lines, removes glitches with a programmable debounce filter, and applies independent programmable SCL and SDA delays for hold-time adjustment. It then produces clean levels plus single-cycle SCL-edge, START and STOP pulses. Debounce and delay lengths come from the peripheral register block.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth per line (≥2).
- `apb_pclk_i`  in  1  system clock (APB clock domain).
- `apb_presetn_i`  in  1  reset: synchronous, active-low.
- `i2c_scl_i`  in  1  raw SCL pin.
- `i2c_sda_i`  in  1  raw SDA pin.
- `i2c_enabled_i`  in  1  when low: no START/STOP pulses, bus_busy held 0.
- `i2c_debounce_len_i`  in  8  debounce length L (cycles).
- `i2c_scl_delay_len_i`  in  8  SCL delay Ds (cycles).
- `i2c_sda_delay_len_i`  in  8  SDA delay Dd (cycles).
- `scl_o` / `sda_o`  out  1  conditioned levels; reset 1.
- `scl_rise_o` / `scl_fall_o`  out  1  one-cycle edge pulses on `scl_o`; reset 0.
- `start_o` / `stop_o`  out  1  one-cycle START/STOP pulses; reset 0.
- `bus_busy_o`  out  1  set by START, cleared by STOP; reset 0.

## Operation
- Reset (apb_presetn_i low at a clock edge):
  - All synchroniser flops, filtered values and delayed values reset to 1.
  - Counters and pending flags reset to 0.
  - Pulses and busy reset to 0.
- Synchroniser: `SYNC_STAGES` flops per line; the last stage is `s`.
- Debounce, per line, 8-bit counter `cnt` and filtered value `f`:
  - Each cycle with `s != f`: if `cnt >= L`, then `f <= s` and `cnt <= 0`; else `cnt++`.
  - Each cycle with `s == f`: `cnt <= 0`.
  - Glitches shorter than L+1 cycles are rejected. L=0 means `f` follows `s` one cycle later.
- Delay, per line, 8-bit counter `dc`, `pend` flag, pending value `pv`, output `o`:
  - On an `f` change (f != last f): load `pv <= f`, `dc <= D`, `pend <= 1`.
  - While pend: if `dc == 0`, then `o <= pv` and `pend <= 0`; else `dc--`.
  - Second change while pend: commit the old `pv` to `o` that cycle, then load the new transition. Ordering of transitions is preserved and none is lost.
- Length registers changing mid-count:
  - The new value applies at the next compare.
  - Debounce uses `>=`, so a shortened L commits immediately.
  - Delay: a loaded `dc` is not reloaded.
- Detection runs on registered previous values `scl_q`, `sda_q` of `scl_o`, `sda_o`:
  - `scl_rise` when `scl_o & ~scl_q`.
  - `scl_fall` when `~scl_o & scl_q`.
  - START when `scl_o & scl_q & sda_q & ~sda_o`.
  - STOP when `scl_o & scl_q & ~sda_q & sda_o`.
  - SCL and SDA changing in the same cycle: edge pulse only, no START/STOP.
- START/STOP are masked by `i2c_enabled_i`. While `i2c_enabled_i` is low, bus_busy is forced to 0.
- Repeated START: bus_busy stays 1 and `start_o` pulses.

## Timing
- Pin to `scl_o`/`sda_o`: SYNC_STAGES + (L+1) + (D+1) cycles. With defaults and L=D=0 this is 4 cycles.
- Pulses and `bus_busy_o` update registered, 1 cycle after the `scl_o`/`sda_o` change.
- All outputs are registered; no combinational pin-to-output path.
- Ds ≠ Dd shifts SDA relative to SCL. A START needs SDA to fall at least 1 cycle after `scl_o` is high.

## Structure
- Shared package `i2cs_pkg`: `I2C_LEN_W = 8` and the reset-level constant `I2C_IDLE_LEVEL = 1'b1`. The defaults (`I2C_DEFAULT_*_LEN`) are already used by the register block.
- One sub-module `i2cs_line_filter`: synchroniser + debounce + delay for a single line, instantiated twice (SCL with Ds, SDA with Dd).
- The top holds edge/START/STOP detection and bus_busy.

## Test plan
- Reset, then lines idle high: all outputs at reset values (scl_o=sda_o=1, pulses 0, busy 0). L=D=0, SCL low at cycle 10 → `scl_o` low at cycle 14 and `scl_fall_o` pulses at cycle 15.
- L=5: 3-cycle SDA low glitch → `sda_o` never changes. 6-cycle low pulse → `sda_o` low at pin+9 for 6 cycles.
- Enabled, SCL high, SDA falls → `start_o` one pulse, busy=1. SDA rises with SCL high → `stop_o` pulse, busy=0. Same with `i2c_enabled_i`=0 → no pulses, busy 0.
- Ds=0, Dd=10, SDA toggles every 4 cycles (L=0) → `sda_o` reproduces every transition, in order, with no loss.
- SCL and SDA driven low on the same cycle with Ds=Dd → `scl_fall_o` only, no `start_o`.
- Reset asserted during a pending delay (Dd=20, mid-count) → next edge: `sda_o`=1, pend cleared, no stray pulse after release.

Source files
------------

// File: rtl/i2cs_pkg.sv
// Shared constants and types for the I2C peripheral input conditioning path.
package i2cs_pkg;

  localparam int unsigned I2C_LEN_W = 8;

  // Level of an idle I2C bus line; also the reset value of all line state.
  localparam logic I2C_IDLE_LEVEL = 1'b1;

  // Power-on lengths programmed by the register block.
  localparam logic [I2C_LEN_W-1:0] I2C_DEFAULT_DEBOUNCE_LEN  = I2C_LEN_W'(0);
  localparam logic [I2C_LEN_W-1:0] I2C_DEFAULT_SCL_DELAY_LEN = I2C_LEN_W'(0);
  localparam logic [I2C_LEN_W-1:0] I2C_DEFAULT_SDA_DELAY_LEN = I2C_LEN_W'(0);

  // Snapshot of both conditioned bus lines.
  typedef struct packed {
    logic scl;
    logic sda;
  } i2c_lines_t;

endpackage

// File: rtl/i2cs_line_filter.sv
// Single-line conditioner: synchroniser, glitch filter and hold-time delay.
module i2cs_line_filter
  import i2cs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin,
  input  logic [I2C_LEN_W-1:0] debounce_len,
  input  logic [I2C_LEN_W-1:0] delay_len,
  output logic                 line
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [I2C_LEN_W-1:0]   cnt_q;
  logic                   filt_q;
  logic                   commit_c;
  logic [I2C_LEN_W-1:0]   dc_q;
  logic                   pend_q;
  logic                   pv_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A filtered-value change happens once the line has disagreed for L+1 cycles.
  assign commit_c = (sync_s != filt_q) && (cnt_q >= debounce_len);

  // Metastability synchroniser, shifting towards the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // Debounce: count consecutive disagreeing cycles, restart on agreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= I2C_IDLE_LEVEL;
    end else if (sync_s != filt_q) begin
      if (commit_c) begin
        filt_q <= sync_s;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + I2C_LEN_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Delay: hold a filtered transition for D cycles; a newer one flushes the older first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dc_q   <= '0;
      pend_q <= 1'b0;
      pv_q   <= I2C_IDLE_LEVEL;
      line   <= I2C_IDLE_LEVEL;
    end else if (commit_c) begin
      if (pend_q) begin
        line <= pv_q;
      end
      pv_q   <= sync_s;
      dc_q   <= delay_len;
      pend_q <= 1'b1;
    end else if (pend_q) begin
      if (dc_q == '0) begin
        line   <= pv_q;
        pend_q <= 1'b0;
      end else begin
        dc_q <= dc_q - I2C_LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2cs_pin_conditioner.sv
// I2C peripheral pin conditioning: clean SCL/SDA levels plus edge, START/STOP and busy.
module i2cs_pin_conditioner
  import i2cs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 apb_pclk_i,
  input  logic                 apb_presetn_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  input  logic                 i2c_enabled_i,
  input  logic [I2C_LEN_W-1:0] i2c_debounce_len_i,
  input  logic [I2C_LEN_W-1:0] i2c_scl_delay_len_i,
  input  logic [I2C_LEN_W-1:0] i2c_sda_delay_len_i,
  output logic                 scl_o,
  output logic                 sda_o,
  output logic                 scl_rise_o,
  output logic                 scl_fall_o,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 bus_busy_o
);

  logic       scl_line;
  logic       sda_line;
  i2c_lines_t cur_c;
  i2c_lines_t prev_q;
  logic       rise_c;
  logic       fall_c;
  logic       start_c;
  logic       stop_c;

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk          (apb_pclk_i),
    .rst_n        (apb_presetn_i),
    .pin          (i2c_scl_i),
    .debounce_len (i2c_debounce_len_i),
    .delay_len    (i2c_scl_delay_len_i),
    .line         (scl_line)
  );

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk          (apb_pclk_i),
    .rst_n        (apb_presetn_i),
    .pin          (i2c_sda_i),
    .debounce_len (i2c_debounce_len_i),
    .delay_len    (i2c_sda_delay_len_i),
    .line         (sda_line)
  );

  assign cur_c.scl = scl_line;
  assign cur_c.sda = sda_line;
  assign scl_o     = scl_line;
  assign sda_o     = sda_line;

  // Edge and bus-condition decode; START/STOP need SCL stable high across the SDA change.
  always_comb begin
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    start_c = 1'b0;
    stop_c  = 1'b0;
    rise_c  = cur_c.scl & ~prev_q.scl;
    fall_c  = ~cur_c.scl & prev_q.scl;
    start_c = i2c_enabled_i & cur_c.scl & prev_q.scl & prev_q.sda & ~cur_c.sda;
    stop_c  = i2c_enabled_i & cur_c.scl & prev_q.scl & ~prev_q.sda & cur_c.sda;
  end

  // Registered pulses, previous levels and bus-busy tracking.
  always_ff @(posedge apb_pclk_i) begin
    if (!apb_presetn_i) begin
      prev_q     <= '{scl: I2C_IDLE_LEVEL, sda: I2C_IDLE_LEVEL};
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      bus_busy_o <= 1'b0;
    end else begin
      prev_q     <= cur_c;
      scl_rise_o <= rise_c;
      scl_fall_o <= fall_c;
      start_o    <= start_c;
      stop_o     <= stop_c;
      if (!i2c_enabled_i) begin
        bus_busy_o <= 1'b0;
      end else if (start_c) begin
        bus_busy_o <= 1'b1;
      end else if (stop_c) begin
        bus_busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2cs_pin_conditioner.sv
// Self-checking bench for i2cs_pin_conditioner: directed scenarios plus random pin activity.
module tb_i2cs_pin_conditioner;
  import i2cs_pkg::*;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_pin;
  logic       sda_pin;
  logic       en;
  logic [7:0] deb_len;
  logic [7:0] scl_dly;
  logic [7:0] sda_dly;
  logic       scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  i2cs_pin_conditioner #(.SYNC_STAGES(SYNC)) u_dut (
    .apb_pclk_i          (clk),
    .apb_presetn_i       (rst_n),
    .i2c_scl_i           (scl_pin),
    .i2c_sda_i           (sda_pin),
    .i2c_enabled_i       (en),
    .i2c_debounce_len_i  (deb_len),
    .i2c_scl_delay_len_i (scl_dly),
    .i2c_sda_delay_len_i (sda_dly),
    .scl_o               (scl_o),
    .sda_o               (sda_o),
    .scl_rise_o          (scl_rise_o),
    .scl_fall_o          (scl_fall_o),
    .start_o             (start_o),
    .stop_o              (stop_o),
    .bus_busy_o          (bus_busy_o)
  );

  // Reference model of one line: pin history, run length of disagreement,
  // and at most one scheduled output event (value, due edge).
  typedef struct {
    logic [31:0] hist;
    int          run;
    logic        f;
    bit          has_ev;
    logic        ev_val;
    int          ev_due;
    logic        o;
  } lm_t;

  lm_t  m_scl, m_sda;
  logic m_scl_q, m_sda_q;
  logic m_rise, m_fall, m_start, m_stop, m_busy;

  function automatic lm_t line_reset();
    lm_t n;
    n.hist = '1; n.run = 0; n.f = 1'b1; n.has_ev = 1'b0;
    n.ev_val = 1'b1; n.ev_due = 0; n.o = 1'b1;
    return n;
  endfunction

  function automatic lm_t line_step(input lm_t st, input logic pin, input int len_l,
                                    input int len_d, input int now);
    lm_t  n;
    logic s;
    bit   moved;
    n     = st;
    moved = 1'b0;
    s     = st.hist[SYNC-1];
    n.hist = {st.hist[30:0], pin};
    if (s !== st.f) begin
      if (st.run >= len_l) begin
        moved = 1'b1;
        n.f   = s;
        n.run = 0;
        if (st.has_ev) n.o = st.ev_val;
        n.has_ev = 1'b1;
        n.ev_val = s;
        n.ev_due = now + len_d + 1;
      end else begin
        n.run = st.run + 1;
      end
    end else begin
      n.run = 0;
    end
    if (!moved && st.has_ev && now == st.ev_due) begin
      n.o      = st.ev_val;
      n.has_ev = 1'b0;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_scl = line_reset(); m_sda = line_reset();
    m_scl_q = 1'b1; m_sda_q = 1'b1;
    m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic st, sp;
    if (!rst_n) begin
      model_reset();
    end else begin
      st = en & m_scl.o & m_scl_q & m_sda_q & ~m_sda.o;
      sp = en & m_scl.o & m_scl_q & ~m_sda_q & m_sda.o;
      m_rise  = m_scl.o & ~m_scl_q;
      m_fall  = ~m_scl.o & m_scl_q;
      m_start = st;
      m_stop  = sp;
      if (!en) m_busy = 1'b0;
      else if (st) m_busy = 1'b1;
      else if (sp) m_busy = 1'b0;
      m_scl_q = m_scl.o;
      m_sda_q = m_sda.o;
      m_scl = line_step(m_scl, scl_pin, int'(deb_len), int'(scl_dly), cyc);
      m_sda = line_step(m_sda, sda_pin, int'(deb_len), int'(sda_dly), cyc);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("m_scl_o",  scl_o,      m_scl.o);
    check("m_sda_o",  sda_o,      m_sda.o);
    check("m_rise",   scl_rise_o, m_rise);
    check("m_fall",   scl_fall_o, m_fall);
    check("m_start",  start_o,    m_start);
    check("m_stop",   stop_o,     m_stop);
    check("m_busy",   bus_busy_o, m_busy);
  endtask

  initial begin
    int   trans;
    int   falls;
    int   starts;
    int   pulses;
    logic last;

    model_reset();
    rst_n = 1'b0; scl_pin = 1'b1; sda_pin = 1'b1; en = 1'b1;
    deb_len = 8'd0; scl_dly = 8'd0; sda_dly = 8'd0;
    repeat (3) tick();
    check("rst_scl_o", scl_o, 1'b1);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_rise",  scl_rise_o, 1'b0);
    check("rst_fall",  scl_fall_o, 1'b0);
    check("rst_start", start_o, 1'b0);
    check("rst_stop",  stop_o, 1'b0);
    check("rst_busy",  bus_busy_o, 1'b0);
    rst_n = 1'b1;
    repeat (6) tick();

    // SCL fall latency with L=D=0: level after 4 edges, pulse on the 5th.
    scl_pin = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("lat_scl_o", scl_o, (k >= 4) ? 1'b0 : 1'b1);
      check("lat_fall",  scl_fall_o, (k == 5) ? 1'b1 : 1'b0);
    end
    scl_pin = 1'b1;
    repeat (8) tick();

    // Debounce L=5: short glitch rejected, 6-cycle pulse passes at pin+9.
    en = 1'b0; deb_len = 8'd5;
    sda_pin = 1'b0;
    repeat (3) tick();
    sda_pin = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check("glitch_sda_o", sda_o, 1'b1);
    end
    sda_pin = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 6) sda_pin = 1'b1;
      check("pulse_sda_o", sda_o, (k >= 9 && k <= 14) ? 1'b0 : 1'b1);
    end
    deb_len = 8'd0;
    repeat (4) tick();

    // START then STOP while enabled.
    en = 1'b1;
    sda_pin = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("start_pulse", start_o, (k == 5) ? 1'b1 : 1'b0);
      check("start_busy",  bus_busy_o, (k >= 5) ? 1'b1 : 1'b0);
    end
    sda_pin = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("stop_pulse", stop_o, (k == 5) ? 1'b1 : 1'b0);
      check("stop_busy",  bus_busy_o, (k >= 5) ? 1'b0 : 1'b1);
    end

    // Same sequence disabled: no pulses, never busy.
    en = 1'b0;
    sda_pin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("dis_start", start_o, 1'b0);
      check("dis_busy",  bus_busy_o, 1'b0);
    end
    sda_pin = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("dis_stop", stop_o, 1'b0);
      check("dis_busy", bus_busy_o, 1'b0);
    end

    // Dd=10 with SDA toggling every 4 cycles: every transition reproduced.
    sda_dly = 8'd10;
    trans = 0;
    last = sda_o;
    for (int k = 0; k < 60; k++) begin
      if (k < 24 && (k % 4) == 0) sda_pin = ~sda_pin;
      tick();
      if (sda_o !== last) begin
        trans++;
        last = sda_o;
      end
    end
    check_int("dly_transitions", trans, 6);
    check("dly_final_sda", sda_o, 1'b1);
    sda_dly = 8'd0;
    repeat (4) tick();

    // SCL and SDA fall together with equal delays: edge only, no START.
    en = 1'b1; scl_dly = 8'd2; sda_dly = 8'd2;
    repeat (4) tick();
    scl_pin = 1'b0; sda_pin = 1'b0;
    falls = 0; starts = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (scl_fall_o === 1'b1) falls++;
      if (start_o === 1'b1) starts++;
    end
    check_int("simul_falls",  falls, 1);
    check_int("simul_starts", starts, 0);
    sda_pin = 1'b1;
    repeat (8) tick();
    scl_pin = 1'b1;
    repeat (8) tick();

    // Reset while an SDA transition is pending in the delay.
    scl_dly = 8'd0; sda_dly = 8'd20;
    sda_pin = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0; sda_pin = 1'b1;
    tick();
    check("rstdly_sda_o", sda_o, 1'b1);
    check("rstdly_start", start_o, 1'b0);
    check("rstdly_busy",  bus_busy_o, 1'b0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("post_rst_sda_o", sda_o, 1'b1);
      if (start_o === 1'b1 || stop_o === 1'b1 || scl_fall_o === 1'b1) pulses++;
    end
    check_int("post_rst_pulses", pulses, 0);
    sda_dly = 8'd0;

    // Random pin activity, length changes, enable toggles and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(63, 0) == 0) deb_len = 8'($urandom_range(4, 0));
      if ($urandom_range(63, 0) == 0) scl_dly = 8'($urandom_range(6, 0));
      if ($urandom_range(63, 0) == 0) sda_dly = 8'($urandom_range(6, 0));
      if ($urandom_range(199, 0) == 0) en = ~en;
      if ($urandom_range(5, 0) == 0) scl_pin = ~scl_pin;
      if ($urandom_range(6, 0) == 0) sda_pin = ~sda_pin;
      rst_n = ($urandom_range(499, 0) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
